// File: rtl/rv_seq_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding, RV32I opcodes
// and the decode helper used by EXECUTE.
package rv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_UNUSED    = 3'd7
  } seq_state_e;

  typedef enum logic [2:0] {
    EX_MEM,
    EX_WB,
    EX_BRANCH,
    EX_ECALL,
    EX_ILLEGAL
  } exec_class_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_PRIV = 3'b000;

  // Decides where EXECUTE sends the instruction; SYSTEM is only legal as ECALL/EBREAK.
  function automatic exec_class_e classify(input logic [6:0] opc, input logic [2:0] f3);
    exec_class_e cls;
    case (opc)
      OPC_LOAD, OPC_STORE:                    cls = EX_MEM;
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR:                      cls = EX_WB;
      OPC_BRANCH:                             cls = EX_BRANCH;
      OPC_SYSTEM: cls = (f3 == F3_PRIV) ? EX_ECALL : EX_ILLEGAL;
      default:                                cls = EX_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle timer shared by the instruction-fetch and data-memory waits;
// flags expiry on the wait cycle in which the count reaches TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam bit               TMO_EN = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0] LIMIT  = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A ready in the final cycle suppresses tick, so ready wins over expiry.
  assign expired = TMO_EN && tick && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: steps each instruction through FETCH..WRITEBACK and
// gates the PC, IR, register-file and data-memory write enables.
module multicycle_sequencer
  import rv_seq_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             cu_ruwr,
  input  logic             cu_dmwr,
  input  logic             br_taken,
  input  logic             im_ready,
  input  logic             dm_ready,
  output logic             im_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             ru_we,
  output logic             dm_req,
  output logic             dm_we,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  seq_state_e       state_q, state_d;
  exec_class_e      ex_cls;
  logic             is_store, retire, busy;
  logic             tmr_clear, tmr_tick, tmr_expired;
  logic             halted_q, illegal_q, bus_err_q;
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;
  logic             unused_br_taken;

  assign unused_br_taken = br_taken;
  assign ex_cls   = classify(opcode, funct3);
  assign is_store = (opcode == OPC_STORE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (im_ready)         state_d = ST_DECODE;
        else if (tmr_expired) state_d = ST_HALT;
      end
      ST_DECODE:    state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        case (ex_cls)
          EX_MEM:    state_d = ST_MEMORY;
          EX_WB:     state_d = ST_WRITEBACK;
          EX_BRANCH: state_d = ST_FETCH;
          default:   state_d = ST_HALT;
        endcase
      end
      ST_MEMORY: begin
        if (dm_ready)         state_d = is_store ? ST_FETCH : ST_WRITEBACK;
        else if (tmr_expired) state_d = ST_HALT;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    im_req = 1'b0;
    ir_we  = 1'b0;
    pc_we  = 1'b0;
    ru_we  = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        im_req = 1'b1;
        ir_we  = im_ready;
      end
      ST_EXECUTE:   pc_we = (ex_cls == EX_BRANCH);
      ST_MEMORY: begin
        dm_req = 1'b1;
        dm_we  = cu_dmwr;
        pc_we  = dm_ready && is_store;
      end
      ST_WRITEBACK: begin
        ru_we = cu_ruwr;
        pc_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Timer restarts on every state change, so each FETCH/MEMORY wait starts from zero.
  assign tmr_clear = (state_d != state_q);
  assign tmr_tick  = ((state_q == ST_FETCH) && !im_ready) ||
                     ((state_q == ST_MEMORY) && !dm_ready);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  assign retire = pc_we || ((state_q == ST_EXECUTE) && (ex_cls == EX_ECALL));
  assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_q + CNT_W'(busy);
      instret_cnt_q <= instret_cnt_q + CNT_W'(retire);
      halted_q      <= halted_q | (state_d == ST_HALT);
      illegal_q     <= illegal_q | ((state_q == ST_EXECUTE) && (ex_cls == EX_ILLEGAL));
      bus_err_q     <= bus_err_q | tmr_expired;
    end
  end

  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign bus_err     = bus_err_q;
  assign state_o     = state_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with TIMEOUT=4; expected values are
// hand-derived from the state sequence of each instruction class.
module tb_multicycle_sequencer;

  localparam int CNT_W = 32;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] BADOP  = 7'b1111111;

  logic             clk = 1'b0;
  logic             reset, start, cu_ruwr, cu_dmwr, br_taken, im_ready, dm_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             im_req, ir_we, pc_we, ru_we, dm_req, dm_we;
  logic             halted, illegal, bus_err;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (4),
    .TMR_W   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .funct3      (funct3),
    .cu_ruwr     (cu_ruwr),
    .cu_dmwr     (cu_dmwr),
    .br_taken    (br_taken),
    .im_ready    (im_ready),
    .dm_ready    (dm_ready),
    .im_req      (im_req),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .ru_we       (ru_we),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .halted      (halted),
    .illegal     (illegal),
    .bus_err     (bus_err),
    .state_o     (state_o),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Enables packed as {im_req, ir_we, pc_we, ru_we, dm_req, dm_we}.
  task automatic check_en(input string tag, input logic [5:0] exp);
    check_val(tag, {26'd0, im_req, ir_we, pc_we, ru_we, dm_req, dm_we}, {26'd0, exp});
  endtask

  // Flags packed as {halted, illegal, bus_err}.
  task automatic check_flags(input string tag, input logic [2:0] exp);
    check_val(tag, {29'd0, halted, illegal, bus_err}, {29'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; funct3 = '0;
    cu_ruwr = 1'b0; cu_dmwr = 1'b0; br_taken = 1'b0;
    im_ready = 1'b0; dm_ready = 1'b0;
    step(); step();
    reset = 1'b0; #1;
    check_val("rst_state", 32'(state_o), 32'd0);
    check_en("rst_en", 6'b000000);
    check_val("rst_cycle", cycle_cnt, 32'd0);
    check_val("rst_instret", instret_cnt, 32'd0);
    check_flags("rst_flags", 3'b000);

    // OP-IMM, zero-wait
    start = 1'b1; im_ready = 1'b1; dm_ready = 1'b1; opcode = OP_IMM; cu_ruwr = 1'b1; #1;
    check_en("opi_idle_en", 6'b000000);
    step(); start = 1'b0; #1;
    check_val("opi_c1_state", 32'(state_o), 32'd1);
    check_en("opi_c1_en", 6'b110000);
    step();
    check_val("opi_c2_state", 32'(state_o), 32'd2);
    check_en("opi_c2_en", 6'b000000);
    step();
    check_val("opi_c3_state", 32'(state_o), 32'd3);
    check_en("opi_c3_en", 6'b000000);
    step();
    check_val("opi_c4_state", 32'(state_o), 32'd5);
    check_en("opi_c4_en", 6'b001100);
    check_val("opi_c4_instret", instret_cnt, 32'd0);
    step();
    check_val("opi_next_state", 32'(state_o), 32'd1);
    check_val("opi_instret", instret_cnt, 32'd1);
    check_val("opi_cycle", cycle_cnt, 32'd4);

    // LOAD with dm_ready delayed 3 cycles
    opcode = LOAD; cu_dmwr = 1'b0; dm_ready = 1'b0; #1;
    check_en("ld_fetch_en", 6'b110000);
    step(); step();
    check_val("ld_exec_state", 32'(state_o), 32'd3);
    step();
    for (int i = 0; i < 3; i++) begin
      check_val("ld_mem_wait_state", 32'(state_o), 32'd4);
      check_en("ld_mem_wait_en", 6'b000010);
      step();
    end
    dm_ready = 1'b1; #1;
    check_val("ld_mem_rdy_state", 32'(state_o), 32'd4);
    check_en("ld_mem_rdy_en", 6'b000010);
    step();
    check_val("ld_wb_state", 32'(state_o), 32'd5);
    check_en("ld_wb_en", 6'b001100);
    step();
    check_val("ld_instret", instret_cnt, 32'd2);
    check_val("ld_cycle", cycle_cnt, 32'd12);

    // STORE with both ControlUnit write requests high
    opcode = STORE; cu_dmwr = 1'b1; cu_ruwr = 1'b1; #1;
    check_en("st_fetch_en", 6'b110000);
    step();
    check_en("st_dec_en", 6'b000000);
    step();
    check_en("st_exec_en", 6'b000000);
    step();
    check_val("st_mem_state", 32'(state_o), 32'd4);
    check_en("st_mem_en", 6'b001011);
    step();
    check_val("st_next_state", 32'(state_o), 32'd1);
    check_val("st_instret", instret_cnt, 32'd3);
    check_val("st_cycle", cycle_cnt, 32'd16);

    // Reset while a store waits in MEMORY
    dm_ready = 1'b0; #1;
    step(); step(); step();
    check_val("rstmem_pre_state", 32'(state_o), 32'd4);
    check_en("rstmem_pre_en", 6'b000011);
    do_reset();
    check_val("rstmem_state", 32'(state_o), 32'd0);
    check_en("rstmem_en", 6'b000000);
    check_val("rstmem_cycle", cycle_cnt, 32'd0);
    check_val("rstmem_instret", instret_cnt, 32'd0);

    // Branch (3 cycles) then ECALL halt
    opcode = BRANCH; im_ready = 1'b1; dm_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0; #1;
    step(); step();
    check_val("br_exec_state", 32'(state_o), 32'd3);
    check_en("br_exec_en", 6'b001000);
    step();
    check_val("br_next_state", 32'(state_o), 32'd1);
    check_val("br_instret", instret_cnt, 32'd1);
    check_val("br_cycle", cycle_cnt, 32'd3);
    opcode = SYSTEM; funct3 = 3'b000; #1;
    step(); step();
    check_en("ecall_exec_en", 6'b000000);
    step();
    check_val("ecall_state", 32'(state_o), 32'd6);
    check_flags("ecall_flags", 3'b100);
    check_val("ecall_instret", instret_cnt, 32'd2);
    do_reset();

    // Unknown opcode
    opcode = BADOP; start = 1'b1;
    step(); start = 1'b0; #1;
    step(); step(); step();
    check_val("ill_state", 32'(state_o), 32'd6);
    check_flags("ill_flags", 3'b110);
    check_val("ill_instret", instret_cnt, 32'd0);
    start = 1'b1;
    step(); step();
    check_val("ill_start_ign_state", 32'(state_o), 32'd6);
    check_en("ill_halt_en", 6'b000000);
    start = 1'b0;
    do_reset();
    check_flags("ill_rst_flags", 3'b000);
    check_val("ill_rst_state", 32'(state_o), 32'd0);

    // SYSTEM with nonzero funct3 is illegal
    opcode = SYSTEM; funct3 = 3'b001; start = 1'b1;
    step(); start = 1'b0; #1;
    step(); step(); step();
    check_flags("sys1_flags", 3'b110);
    check_val("sys1_instret", instret_cnt, 32'd0);
    funct3 = 3'b000;
    do_reset();

    // Fetch timeout: im_ready never arrives
    im_ready = 1'b0; opcode = OP_IMM; start = 1'b1;
    step(); start = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check_val("tmo_wait_state", 32'(state_o), 32'd1);
      check_en("tmo_wait_en", 6'b100000);
      step();
    end
    check_val("tmo_state", 32'(state_o), 32'd6);
    check_flags("tmo_flags", 3'b101);
    check_en("tmo_halt_en", 6'b000000);
    check_val("tmo_cycle", cycle_cnt, 32'd4);
    do_reset();

    // Ready on the timeout cycle wins; MEMORY wait restarts the timer
    im_ready = 1'b0; start = 1'b1;
    step(); start = 1'b0; #1;
    step(); step(); step();
    im_ready = 1'b1; opcode = LOAD; cu_dmwr = 1'b0; dm_ready = 1'b0; #1;
    check_en("rw_fetch_en", 6'b110000);
    step();
    check_val("rw_dec_state", 32'(state_o), 32'd2);
    check_flags("rw_dec_flags", 3'b000);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      check_val("rw_mem_state", 32'(state_o), 32'd4);
      step();
    end
    dm_ready = 1'b1; #1;
    step();
    check_val("rw_wb_state", 32'(state_o), 32'd5);
    step();
    check_val("rw_next_state", 32'(state_o), 32'd1);
    check_flags("rw_flags", 3'b000);
    check_val("rw_instret", instret_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
